// File: rtl/mcs4_bus_tracer.sv
// MCS-4 bus instruction-fetch tracer.
// Follows the 8-phase cycle and queues {cmrom, addr, opr, opa} records.
module mcs4_bus_tracer #(
  parameter int DEPTH       = 4,
  parameter bit DATA_INVERT = 1'b0
) (
  input  logic        sysclk,
  input  logic        poc_n,
  input  logic        clk2,
  input  logic        sync,
  input  logic [3:0]  data,
  input  logic        cmrom,
  output logic [20:0] trace_data,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [7:0]  overflow_cnt,
  output logic        sync_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    S_UNSYNC, S_A1, S_A2, S_A3,
    S_M1, S_M2, S_X1, S_X2, S_X3
  } state_t;

  state_t state_q, state_d;

  logic          c2_q, c2_qq;
  logic          fall;
  logic [3:0]    nib;
  logic          err_set;
  logic          push;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;
  logic [11:0]   addr_q;
  logic [3:0]    opr_q;
  logic          cm_q;
  logic [20:0]   rec;
  logic [20:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    ovf_q;
  logic          err_q;

  assign fall    = c2_qq & ~c2_q;
  assign nib     = DATA_INVERT ? ~data : data;
  assign rec     = {cm_q, addr_q, opr_q, nib};
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = trace_valid & trace_ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign trace_valid  = (count_q != '0);
  assign trace_data   = trace_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow_cnt = ovf_q;
  assign sync_err     = err_q;

  // clk2 synchroniser feeding the falling-edge detector
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      c2_q  <= 1'b0;
      c2_qq <= 1'b0;
    end else begin
      c2_q  <= clk2;
      c2_qq <= c2_q;
    end
  end

  // phase state register
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) state_q <= S_UNSYNC;
    else        state_q <= state_d;
  end

  // phase sequencing, sync checking and push request
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    push    = 1'b0;
    if (fall) begin
      case (state_q)
        S_UNSYNC: if (sync) state_d = S_A1;
        S_X3: begin
          state_d = sync ? S_A1 : S_UNSYNC;
          err_set = ~sync;
        end
        default: begin
          if (sync) begin
            state_d = S_A1;
            err_set = 1'b1;
          end else begin
            case (state_q)
              S_A1:    state_d = S_A2;
              S_A2:    state_d = S_A3;
              S_A3:    state_d = S_M1;
              S_M1:    state_d = S_M2;
              S_M2:    state_d = S_X1;
              S_X1:    state_d = S_X2;
              S_X2:    state_d = S_X3;
              default: state_d = S_UNSYNC;
            endcase
            push = (state_q == S_M2);
          end
        end
      endcase
    end
  end

  // partial record capture; a restart simply overwrites it
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      addr_q <= '0;
      opr_q  <= '0;
      cm_q   <= 1'b0;
    end else if (fall) begin
      case (state_q)
        S_A1: addr_q[3:0]  <= nib;
        S_A2: addr_q[7:4]  <= nib;
        S_A3: begin
          addr_q[11:8] <= nib;
          cm_q         <= cmrom;
        end
        S_M1: opr_q <= nib;
        default: ;
      endcase
    end
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= rec;
  end

  // FIFO pointers, occupancy, drop counter and sticky error
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !pop)      count_q <= count_q + CW'(1);
      else if (!do_push && pop) count_q <= count_q - CW'(1);
      if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// Directed bench for mcs4_bus_tracer.
// Two instances: plain data bus and inverted data bus.
module tb_mcs4_bus_tracer;

  logic        sysclk = 1'b0;
  logic        poc_n  = 1'b0;
  logic        clk2   = 1'b0;
  logic        sync   = 1'b0;
  logic [3:0]  data   = 4'h0;
  logic        cmrom  = 1'b0;
  logic        ready  = 1'b0;
  logic [20:0] td0, td1;
  logic        tv0, tv1;
  logic [7:0]  ov0, ov1;
  logic        se0, se1;

  int nvec = 0;
  int nerr = 0;

  logic [20:0] q0[$];
  logic [20:0] q1[$];
  logic [20:0] ex[6];

  always #5 sysclk = ~sysclk;

  mcs4_bus_tracer #(.DEPTH(4), .DATA_INVERT(1'b0)) dut0 (
    .sysclk(sysclk), .poc_n(poc_n), .clk2(clk2), .sync(sync),
    .data(data), .cmrom(cmrom), .trace_data(td0), .trace_valid(tv0),
    .trace_ready(ready), .overflow_cnt(ov0), .sync_err(se0)
  );

  mcs4_bus_tracer #(.DEPTH(4), .DATA_INVERT(1'b1)) dut1 (
    .sysclk(sysclk), .poc_n(poc_n), .clk2(clk2), .sync(sync),
    .data(data), .cmrom(cmrom), .trace_data(td1), .trace_valid(tv1),
    .trace_ready(ready), .overflow_cnt(ov1), .sync_err(se1)
  );

  // beats accepted at the coming posedge
  always begin
    @(negedge sysclk);
    #1;
    if (poc_n && tv0 && ready) q0.push_back(td0);
    if (poc_n && tv1 && ready) q1.push_back(td1);
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [20:0] mk(input logic [3:0] a1, a2, a3,
                                     input logic [3:0] m1, m2,
                                     input logic cm);
    return {cm, a3, a2, a1, m1, m2};
  endfunction

  // one bus phase; rp pulses ready exactly on the phase edge
  task automatic ph(input logic [3:0] d, input logic s,
                    input logic cm, input bit rp);
    @(negedge sysclk);
    data = d; sync = s; cmrom = cm; clk2 = 1'b1;
    repeat (2) @(negedge sysclk);
    clk2 = 1'b0;
    @(negedge sysclk);
    if (rp) ready = 1'b1;
    @(negedge sysclk);
    if (rp) ready = 1'b0;
    @(negedge sysclk);
    sync = 1'b0;
  endtask

  task automatic cyc(input logic [3:0] a1, a2, a3, m1, m2,
                     input logic cm, input logic x3s, input bit rp);
    ph(a1, 1'b0, 1'b0, 1'b0);
    ph(a2, 1'b0, 1'b0, 1'b0);
    ph(a3, 1'b0, cm, 1'b0);
    ph(m1, 1'b0, 1'b0, 1'b0);
    ph(m2, 1'b0, 1'b0, rp);
    ph(4'h0, 1'b0, 1'b0, 1'b0);
    ph(4'h0, 1'b0, 1'b0, 1'b0);
    ph(4'h0, x3s, 1'b0, 1'b0);
  endtask

  task automatic drain();
    @(negedge sysclk);
    ready = 1'b1;
    repeat (12) @(negedge sysclk);
    ready = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    poc_n = 1'b0;
    repeat (2) @(negedge sysclk);
    poc_n = 1'b1;
  endtask

  initial begin
    // T1: reset values, reset mid-M1, resync required
    repeat (3) @(negedge sysclk);
    chk("rst_valid", 32'(tv0), 32'h0);
    chk("rst_data", 32'(td0), 32'h0);
    chk("rst_ovf", 32'(ov0), 32'h0);
    chk("rst_err", 32'(se0), 32'h0);
    poc_n = 1'b1;
    ph(4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 1'b0, 1'b1, 1'b0);
    chk("t1_queued", 32'(tv0), 32'h1);
    ph(4'h7, 1'b0, 1'b0, 1'b0);
    ph(4'h7, 1'b0, 1'b0, 1'b0);
    ph(4'h7, 1'b0, 1'b1, 1'b0);
    @(negedge sysclk);
    data = 4'h9; clk2 = 1'b1;
    poc_n = 1'b0;
    #1;
    chk("t1_mid_valid", 32'(tv0), 32'h0);
    chk("t1_mid_data", 32'(td0), 32'h0);
    repeat (2) @(negedge sysclk);
    clk2 = 1'b0;
    repeat (2) @(negedge sysclk);
    poc_n = 1'b1;
    for (int i = 0; i < 8; i++) ph(4'h6, 1'b0, 1'b1, 1'b0);
    chk("t1_no_rec_unsync", 32'(tv0), 32'h0);

    // T2: single record
    ph(4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'h3, 4'h2, 4'h1, 4'hD, 4'h5, 1'b1, 1'b1, 1'b0);
    chk("t2_valid", 32'(tv0), 32'h1);
    chk("t2_head", 32'(td0), 32'h1123D5);
    chk("t2_err", 32'(se0), 32'h0);
    q0.delete();
    drain();
    chk("t2_beats", 32'(q0.size()), 32'd1);
    if (q0.size() > 0) chk("t2_beat", 32'(q0[0]), 32'h1123D5);
    chk("t2_empty", 32'(tv0), 32'h0);

    // T3: overflow with stalled consumer
    for (int i = 0; i < 6; i++) begin
      ex[i] = mk(4'(i), 4'(i + 1), 4'(i + 2), 4'(4'hA ^ 4'(i)),
                 4'(i + 3), 1'(i));
      cyc(4'(i), 4'(i + 1), 4'(i + 2), 4'(4'hA ^ 4'(i)),
          4'(i + 3), 1'(i), 1'b1, 1'b0);
    end
    chk("t3_ovf", 32'(ov0), 32'd2);
    chk("t3_head", 32'(td0), 32'(ex[0]));
    q0.delete();
    drain();
    chk("t3_beats", 32'(q0.size()), 32'd4);
    for (int i = 0; i < 4 && i < q0.size(); i++)
      chk($sformatf("t3_beat%0d", i), 32'(q0[i]), 32'(ex[i]));

    // T4: push and pop on the same edge while full
    for (int i = 0; i < 5; i++)
      ex[i] = mk(4'(15 - i), 4'(i), 4'h8, 4'(i + 7), 4'(2 * i), 1'(~i));
    for (int i = 0; i < 4; i++)
      cyc(4'(15 - i), 4'(i), 4'h8, 4'(i + 7), 4'(2 * i), 1'(~i),
          1'b1, 1'b0);
    chk("t4_full_ovf", 32'(ov0), 32'd2);
    q0.delete();
    cyc(4'(11), 4'(4), 4'h8, 4'(11), 4'(8), 1'b1, 1'b1, 1'b1);
    chk("t4_ovf_same", 32'(ov0), 32'd2);
    chk("t4_one_pop", 32'(q0.size()), 32'd1);
    drain();
    chk("t4_beats", 32'(q0.size()), 32'd5);
    for (int i = 0; i < 5 && i < q0.size(); i++)
      chk($sformatf("t4_beat%0d", i), 32'(q0[i]), 32'(ex[i]));

    // T5: missing sync at X3, then recovery
    do_reset();
    chk("t5_rst_ovf", 32'(ov0), 32'h0);
    ph(4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0);
    chk("t5_err", 32'(se0), 32'h1);
    for (int i = 0; i < 3; i++) ph(4'hF, 1'b0, 1'b1, 1'b0);
    ph(4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 1'b1, 1'b1, 1'b0);
    chk("t5_err_sticky", 32'(se0), 32'h1);
    q0.delete();
    drain();
    chk("t5_beats", 32'(q0.size()), 32'd2);
    if (q0.size() == 2) begin
      chk("t5_beat0", 32'(q0[0]), 32'h0654_78);
      chk("t5_beat1", 32'(q0[1]), 32'h1BA9_CE);
    end

    // T6: inverted pads, and sync at M1 restarts the cycle
    do_reset();
    chk("t6_rst_err", 32'(se1), 32'h0);
    ph(4'h0, 1'b1, 1'b0, 1'b0);
    cyc(4'hC, 4'hD, 4'hE, 4'h2, 4'hA, 1'b0, 1'b1, 1'b0);
    chk("t6_inv_head", 32'(td1), 32'h0123D5);
    chk("t6_raw_head", 32'(td0), 32'h0EDC2A);
    chk("t6_err0", 32'(se1), 32'h0);
    ph(4'h8, 1'b0, 1'b0, 1'b0);
    ph(4'h7, 1'b0, 1'b0, 1'b0);
    ph(4'h6, 1'b0, 1'b1, 1'b0);
    ph(4'h5, 1'b1, 1'b0, 1'b0);
    chk("t6_m1_sync_err", 32'(se1), 32'h1);
    cyc(4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 1'b1, 1'b1, 1'b0);
    q1.delete();
    drain();
    chk("t6_beats", 32'(q1.size()), 32'd2);
    if (q1.size() == 2) begin
      chk("t6_beat0", 32'(q1[0]), 32'h0123D5);
      chk("t6_beat1", 32'(q1[1]), 32'h1987AB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
